alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared external ALU.
// Optional feature macro: ALU_ARB_OPCHECK_EN rejects opcodes 0 and 7 with an
// err-qualified done and leaves the ALU drive untouched.
module alu_arbiter (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0,
  input  logic        req1,
  input  logic [2:0]  op0,
  input  logic [2:0]  op1,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  input  logic [15:0] alu_c,
  input  logic        alu_z,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] result,
  output logic        zero,
  output logic        err,
  output logic        busy,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op
);

  // REJECT is only reachable when opcode checking is compiled in.
  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, REJECT} state_t;

  state_t state, next_state;
  logic   ptr;
  logic   owner;
  logic   win;
  logic   start;
  logic   illegal_op;

  // Contest winner: the pointer decides ties, otherwise the lone requester wins.
  assign win = (req0 & req1) ? ptr : req1;

`ifdef ALU_ARB_OPCHECK_EN
  logic [2:0] win_op;
  assign win_op     = win ? op1 : op0;
  assign illegal_op = (win_op == 3'd0) || (win_op == 3'd7);
`else
  assign illegal_op = 1'b0;
`endif

  assign busy = (state != IDLE);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode; start marks the cycle in which a request is accepted.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          start      = 1'b1;
          next_state = illegal_op ? REJECT : DRIVE;
        end
      end
      DRIVE:   next_state = SETTLE;
      SETTLE:  next_state = IDLE;
      REJECT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Grant/done pulses, pointer update, ALU drive capture and result capture.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr    <= 1'b0;
      owner  <= 1'b0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      result <= 16'h0000;
      zero   <= 1'b0;
      alu_a  <= 16'h0000;
      alu_b  <= 16'h0000;
      alu_op <= 3'd0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (start) begin
        ptr   <= ~win;
        owner <= win;
        gnt0  <= ~win;
        gnt1  <= win;
        if (!illegal_op) begin
          alu_a  <= win ? a1 : a0;
          alu_b  <= win ? b1 : b0;
          alu_op <= win ? op1 : op0;
        end
      end
      if (state == SETTLE) begin
        result <= alu_c;
        zero   <= alu_z;
      end
      if (state == SETTLE || state == REJECT) begin
        done0 <= ~owner;
        done1 <= owner;
      end
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  // err accompanies the done pulse that closes a rejected operation.
  always_ff @(posedge clk) begin
    if (!rstn) err <= 1'b0;
    else       err <= (state == REJECT);
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a small external ALU model.
// Honours ALU_ARB_OPCHECK_EN for the illegal-opcode scenario.
module tb_alu_arbiter;

  logic        clk;
  logic        rstn;
  logic        req0, req1;
  logic [2:0]  op0, op1;
  logic [15:0] a0, b0, a1, b1;
  logic [15:0] alu_c;
  logic        alu_z;
  logic        gnt0, gnt1, done0, done1;
  logic [15:0] result;
  logic        zero, err, busy;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_op;

  int nChecks = 0;
  int nFails  = 0;

  alu_arbiter dut (
    .clk(clk), .rstn(rstn),
    .req0(req0), .req1(req1),
    .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .alu_c(alu_c), .alu_z(alu_z),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .zero(zero), .err(err), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU model; subtract is B minus A for this ALU.
  always_comb begin
    case (alu_op)
      3'd1:    alu_c = alu_a;
      3'd2:    alu_c = alu_a + alu_b;
      3'd3:    alu_c = alu_b - alu_a;
      3'd4:    alu_c = alu_a << alu_b;
      3'd5:    alu_c = alu_a >> alu_b;
      3'd6:    alu_c = alu_a | alu_b;
      default: alu_c = 16'h0000;
    endcase
  end

  // Registered zero flag of the ALU: B equal to zero.
  always @(posedge clk) alu_z <= (alu_b == 16'h0000);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic which, input logic r, input logic [2:0] op,
                               input logic [15:0] a, input logic [15:0] b);
    if (which) begin
      req1 = r; op1 = op; a1 = a; b1 = b;
    end else begin
      req0 = r; op0 = op; a0 = a; b0 = b;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    nChecks++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkReset(input string phase);
    checkOutput({phase, " gnt0"},   16'(gnt0),   16'd0);
    checkOutput({phase, " gnt1"},   16'(gnt1),   16'd0);
    checkOutput({phase, " done0"},  16'(done0),  16'd0);
    checkOutput({phase, " done1"},  16'(done1),  16'd0);
    checkOutput({phase, " err"},    16'(err),    16'd0);
    checkOutput({phase, " busy"},   16'(busy),   16'd0);
    checkOutput({phase, " result"}, result,      16'h0000);
    checkOutput({phase, " zero"},   16'(zero),   16'd0);
    checkOutput({phase, " alu_a"},  alu_a,       16'h0000);
    checkOutput({phase, " alu_b"},  alu_b,       16'h0000);
    checkOutput({phase, " alu_op"}, 16'(alu_op), 16'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    applyStimulus(1'b1, 1'b0, 3'd0, 16'h0, 16'h0);
    tick();
    tick();
    $display("[TB] reset state");
    checkReset("reset");

    // Single requester add, accepted on the first edge out of reset.
    $display("[TB] single add");
    rstn = 1'b1;
    applyStimulus(1'b0, 1'b1, 3'd2, 16'h0003, 16'h0004);
    tick();
    checkOutput("add gnt0", 16'(gnt0), 16'd1);
    checkOutput("add gnt1", 16'(gnt1), 16'd0);
    checkOutput("add busy", 16'(busy), 16'd1);
    checkOutput("add alu_a", alu_a, 16'h0003);
    checkOutput("add alu_b", alu_b, 16'h0004);
    checkOutput("add alu_op", 16'(alu_op), 16'd2);
    req0 = 1'b0;
    tick();
    checkOutput("add settle gnt0", 16'(gnt0), 16'd0);
    checkOutput("add settle done0", 16'(done0), 16'd0);
    tick();
    checkOutput("add done0", 16'(done0), 16'd1);
    checkOutput("add result", result, 16'h0007);
    checkOutput("add zero", 16'(zero), 16'd0);
    checkOutput("add idle busy", 16'(busy), 16'd0);
    tick();
    checkOutput("add done0 pulse", 16'(done0), 16'd0);
    checkOutput("add result hold", result, 16'h0007);

    // Simultaneous requests right after reset: requester 0 first.
    $display("[TB] simultaneous after reset");
    rstn = 1'b0;
    tick();
    checkOutput("rst2 result", result, 16'h0000);
    rstn = 1'b1;
    applyStimulus(1'b0, 1'b1, 3'd3, 16'h0001, 16'h0005);
    applyStimulus(1'b1, 1'b1, 3'd6, 16'h00F0, 16'h000F);
    tick();
    checkOutput("sim gnt0", 16'(gnt0), 16'd1);
    checkOutput("sim gnt1", 16'(gnt1), 16'd0);
    req0 = 1'b0;
    tick();
    checkOutput("sim held gnt1", 16'(gnt1), 16'd0);
    tick();
    checkOutput("sim done0", 16'(done0), 16'd1);
    checkOutput("sim result0", result, 16'h0004);
    checkOutput("sim done-cycle gnt1", 16'(gnt1), 16'd0);
    tick();
    checkOutput("sim gnt1", 16'(gnt1), 16'd1);
    checkOutput("sim alu_a1", alu_a, 16'h00F0);
    req1 = 1'b0;
    tick();
    tick();
    checkOutput("sim done1", 16'(done1), 16'd1);
    checkOutput("sim done0 off", 16'(done0), 16'd0);
    checkOutput("sim result1", result, 16'h00FF);

    // Both requests held for four operations: grants alternate.
    $display("[TB] alternating grants");
    applyStimulus(1'b0, 1'b1, 3'd1, 16'h1111, 16'h0001);
    applyStimulus(1'b1, 1'b1, 3'd1, 16'h2222, 16'h0002);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("alt%0d gnt0", k), 16'(gnt0), (k % 2 == 0) ? 16'd1 : 16'd0);
      checkOutput($sformatf("alt%0d gnt1", k), 16'(gnt1), (k % 2 == 1) ? 16'd1 : 16'd0);
      tick();
      tick();
      checkOutput($sformatf("alt%0d done0", k), 16'(done0), (k % 2 == 0) ? 16'd1 : 16'd0);
      checkOutput($sformatf("alt%0d done1", k), 16'(done1), (k % 2 == 1) ? 16'd1 : 16'd0);
      checkOutput($sformatf("alt%0d result", k), result, (k % 2 == 0) ? 16'h1111 : 16'h2222);
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // Right shifts, second one issued back-to-back from the done cycle.
    $display("[TB] shifts and zero flag");
    tick();
    applyStimulus(1'b0, 1'b1, 3'd5, 16'h0080, 16'h0006);
    tick();
    checkOutput("shr1 gnt0", 16'(gnt0), 16'd1);
    req0 = 1'b0;
    tick();
    tick();
    checkOutput("shr1 done0", 16'(done0), 16'd1);
    checkOutput("shr1 result", result, 16'h0002);
    checkOutput("shr1 zero", 16'(zero), 16'd0);
    applyStimulus(1'b0, 1'b1, 3'd5, 16'h0000, 16'h0000);
    tick();
    checkOutput("shr2 b2b gnt0", 16'(gnt0), 16'd1);
    checkOutput("shr2 alu_b", alu_b, 16'h0000);
    req0 = 1'b0;
    tick();
    tick();
    checkOutput("shr2 done0", 16'(done0), 16'd1);
    checkOutput("shr2 result", result, 16'h0000);
    checkOutput("shr2 zero", 16'(zero), 16'd1);

    // Reset during SETTLE aborts, then the reissued request completes.
    $display("[TB] reset in settle");
    applyStimulus(1'b1, 1'b1, 3'd2, 16'h0005, 16'h0006);
    tick();
    checkOutput("abort gnt1", 16'(gnt1), 16'd1);
    req1 = 1'b0;
    tick();
    checkOutput("abort settle busy", 16'(busy), 16'd1);
    rstn = 1'b0;
    tick();
    checkReset("abort");
    rstn = 1'b1;
    req1 = 1'b1;
    tick();
    checkOutput("reissue gnt1", 16'(gnt1), 16'd1);
    checkOutput("reissue no done1", 16'(done1), 16'd0);
    req1 = 1'b0;
    tick();
    tick();
    checkOutput("reissue done1", 16'(done1), 16'd1);
    checkOutput("reissue result", result, 16'h000B);

    // Opcode 7 from requester 1.
    $display("[TB] opcode 7");
    applyStimulus(1'b1, 1'b1, 3'd7, 16'h1234, 16'h0001);
    tick();
    checkOutput("op7 gnt1", 16'(gnt1), 16'd1);
    req1 = 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
    checkOutput("op7 alu_op kept", 16'(alu_op), 16'd2);
    tick();
    checkOutput("op7 done1", 16'(done1), 16'd1);
    checkOutput("op7 err", 16'(err), 16'd1);
    checkOutput("op7 result kept", result, 16'h000B);
    checkOutput("op7 alu_a kept", alu_a, 16'h0005);
    tick();
    checkOutput("op7 err pulse", 16'(err), 16'd0);
    checkOutput("op7 idle busy", 16'(busy), 16'd0);
`else
    checkOutput("op7 alu_op fwd", 16'(alu_op), 16'd7);
    tick();
    checkOutput("op7 settle done1", 16'(done1), 16'd0);
    tick();
    checkOutput("op7 done1", 16'(done1), 16'd1);
    checkOutput("op7 err", 16'(err), 16'd0);
    checkOutput("op7 result", result, 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
